lane_scatter: RTL and testbench
===============================

# lane_scatter

Sequential 1-to-7 distributor. It is the scatter counterpart of the 7-input, 3-bit-select word mux in the reverse-converter datapath. A stream of WIDTH-bit words arrives, each tagged with a 3-bit lane code; every word is written into one of seven registered lanes A..G. When all seven lanes hold fresh data, the block presents them as one parallel frame to the downstream converter stage under a valid/ready handshake.

## Interface
- WIDTH, 8, data width of each word and each lane register
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  incoming word
- in_sel  input  3  lane code: 001=A, 010=B, 011=C, 100=D, 101=E, 110=F, 111=G, 000=null
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block can accept a word this cycle
- out_A..out_G  output  WIDTH each  lane registers, seven ports
- load_mask  output  7  bit0=A … bit6=G; bit set means lane written in current frame
- frame_valid  output  1  all seven lanes loaded, frame on out_A..out_G
- frame_ready  input  1  downstream consumes frame
- dup_err  output  1  one-cycle pulse: accepted word hit an already-loaded lane
- frame_count  output  8  frames consumed, wraps 255→0

## Operation
- Reset behaviour (rst high at a clk edge):
  - out_A..out_G=0, load_mask=0, frame_valid=0, dup_err=0, frame_count=0.
  - rst overrides everything, including a mid-frame or pending frame; partial data is discarded.
- Two states, encoded by frame_valid:
  - FILL (frame_valid=0)
  - HOLD (frame_valid=1)
- in_ready = ~frame_valid, driven combinationally from the registered state.
- Accept rule: a word is accepted when in_valid & in_ready.
  - in_sel=001..111: the lane register takes in_data and its load_mask bit sets.
  - in_sel=000: the word is consumed and discarded. No register, mask or flag changes.
- Duplicate write: an accepted word targets a lane whose mask bit is already set.
  - The lane is overwritten with the new data.
  - dup_err pulses high for one cycle.
  - The mask is unchanged.
- FILL→HOLD: taken at the edge where an accepted write makes load_mask = 7'h7F.
- HOLD:
  - in_ready=0; in_valid is ignored.
  - out_A..out_G and load_mask are stable.
- HOLD→FILL: taken at the edge where frame_valid & frame_ready.
  - load_mask clears to 0 and frame_count increments.
  - Lane registers retain their values until overwritten; the mask, not the data, defines freshness.
- frame_ready is ignored in FILL.
- Ordering: lanes may arrive in any order. Null codes and duplicates may be interleaved.

## Timing
- Write latency: a word accepted at edge N is visible on its out_X and in load_mask after edge N.
- Frame latency:
  - The seventh distinct lane accepted at edge N gives frame_valid=1 after edge N, in the same cycle its data appears.
  - Minimum frame period is 8 cycles: 7 fill cycles plus 1 handshake cycle.
- Back-pressure: after a HOLD→FILL edge, in_ready is high in the very next cycle. There are no bubbles beyond the handshake cycle.
- Simultaneous events:
  - A word presented in the same cycle as the frame handshake is not accepted, because in_ready=0. The source must hold it.
  - A duplicate on the completing edge cannot occur, because a duplicate never changes the mask.
- dup_err is high only in the cycle after the offending accept edge.
- frame_count wraps modulo 256 with no flag.

## Test plan
- Reset then fill in order: send sel 001..111 with data 8'h11..8'h77 on consecutive cycles.
  - frame_valid rises after the 7th edge; out_A=8'h11 … out_G=8'h77; load_mask=7'h7F.
  - With frame_ready=1, one cycle later frame_valid=0, mask=0, frame_count=1.
- Out-of-order fill with nulls: send sel 111,000,001,000,100,010,110,011,101.
  - Null words are dropped and mask bits set in arrival order.
  - frame_valid rises only after sel 101.
- Duplicate: send A=8'hAA then A=8'h55, then the remaining six lanes.
  - dup_err pulses once; out_A=8'h55 when the frame is presented.
- Back-pressure:
  - Hold frame_ready=0 for 10 cycles while in_valid=1: in_ready stays 0 and outputs stay stable.
  - Raise frame_ready: the next frame's first word is accepted in the cycle after the handshake.
- Reset mid-operation:
  - Assert rst with 4 lanes loaded: all outputs return to 0.
  - Assert rst in HOLD: frame_valid drops with no frame_count increment.
- Wrap: complete 256 frames; frame_count returns to 0.

Source files
------------

// File: rtl/lane_scatter.sv
// lane_scatter: steers a tagged word stream into seven lane registers (A..G)
// and presents them as one parallel frame once every lane holds fresh data.
module lane_scatter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_A,
  output logic [WIDTH-1:0] out_B,
  output logic [WIDTH-1:0] out_C,
  output logic [WIDTH-1:0] out_D,
  output logic [WIDTH-1:0] out_E,
  output logic [WIDTH-1:0] out_F,
  output logic [WIDTH-1:0] out_G,
  output logic [6:0]       load_mask,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             dup_err,
  output logic [7:0]       frame_count
);

  logic [WIDTH-1:0] lane_q [7];
  logic [WIDTH-1:0] lane_d [7];
  logic [6:0]       mask_q, mask_d;
  logic             fv_q, fv_d;
  logic             dup_q, dup_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             accept;

  // frame_valid doubles as the FILL/HOLD state; no input is taken while holding
  assign in_ready = ~fv_q;
  assign accept   = in_valid & ~fv_q;

  // Next-state: lane writes and mask update in FILL, frame handshake in HOLD
  always_comb begin
    lane_d = lane_q;
    mask_d = mask_q;
    fv_d   = fv_q;
    dup_d  = 1'b0;
    cnt_d  = cnt_q;
    if (fv_q) begin
      if (frame_ready) begin
        fv_d   = 1'b0;
        mask_d = '0;
        cnt_d  = cnt_q + 8'd1;
      end
    end else if (accept && (in_sel != 3'd0)) begin
      for (int i = 0; i < 7; i++) begin
        if (in_sel == 3'(i + 1)) begin
          lane_d[i] = in_data;
          mask_d[i] = 1'b1;
          // A second write to a fresh lane overwrites it but is flagged
          if (mask_q[i]) dup_d = 1'b1;
        end
      end
      if (mask_d == 7'h7F) fv_d = 1'b1;
    end
  end

  // State and lane registers; reset discards any partial or pending frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) lane_q[i] <= '0;
      mask_q <= '0;
      fv_q   <= 1'b0;
      dup_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 7; i++) lane_q[i] <= lane_d[i];
      mask_q <= mask_d;
      fv_q   <= fv_d;
      dup_q  <= dup_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_A       = lane_q[0];
  assign out_B       = lane_q[1];
  assign out_C       = lane_q[2];
  assign out_D       = lane_q[3];
  assign out_E       = lane_q[4];
  assign out_F       = lane_q[5];
  assign out_G       = lane_q[6];
  assign load_mask   = mask_q;
  assign frame_valid = fv_q;
  assign dup_err     = dup_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_lane_scatter.sv
// Bench for lane_scatter: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against a behavioural frame model.
module tb_lane_scatter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_A, out_B, out_C, out_D, out_E, out_F, out_G;
  logic [6:0] load_mask;
  logic       frame_valid;
  logic       frame_ready;
  logic       dup_err;
  logic [7:0] frame_count;

  int tests = 0;
  int fails = 0;

  lane_scatter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_D(out_D),
    .out_E(out_E), .out_F(out_F), .out_G(out_G),
    .load_mask(load_mask), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .dup_err(dup_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: which lanes are fresh, what they hold, frame pending or not
  logic [7:0] m_lane [7];
  bit         m_fresh [7];
  bit         m_pending;
  bit         m_dup;
  int         m_frames;
  bit         chk_on = 1'b0;

  function automatic bit all_fresh();
    for (int i = 0; i < 7; i++) if (!m_fresh[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    chk_on = 1'b1;
    if (rst) begin
      for (int i = 0; i < 7; i++) begin m_lane[i] = 8'h00; m_fresh[i] = 1'b0; end
      m_pending = 1'b0;
      m_dup     = 1'b0;
      m_frames  = 0;
    end else begin
      m_dup = 1'b0;
      if (m_pending) begin
        if (frame_ready) begin
          m_pending = 1'b0;
          for (int i = 0; i < 7; i++) m_fresh[i] = 1'b0;
          m_frames = (m_frames + 1) % 256;
        end
      end else if (in_valid && in_sel != 3'd0) begin
        int k;
        k = int'(in_sel) - 1;
        m_dup      = m_fresh[k];
        m_lane[k]  = in_data;
        m_fresh[k] = 1'b1;
        if (all_fresh()) m_pending = 1'b1;
      end
    end
  end

  // Compare process: DUT against model on every falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      logic [7:0] o [7];
      logic [6:0] em;
      o = '{out_A, out_B, out_C, out_D, out_E, out_F, out_G};
      em = '0;
      for (int i = 0; i < 7; i++) begin
        em[i] = m_fresh[i];
        chk($sformatf("lane%0d", i), 32'(o[i]), 32'(m_lane[i]));
      end
      chk("load_mask", 32'(load_mask), 32'(em));
      chk("frame_valid", 32'(frame_valid), 32'(m_pending));
      chk("in_ready", 32'(in_ready), 32'(!m_pending));
      chk("dup_err", 32'(dup_err), 32'(m_dup));
      chk("frame_count", 32'(frame_count), 32'(m_frames));
    end
  end

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d, input logic fr);
    in_valid = v; in_sel = s; in_data = d; frame_ready = fr;
    @(negedge clk);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 1; i <= 7; i++) drive(1'b1, 3'(i), base + 8'(i), 1'b0);
  endtask

  initial begin
    logic [2:0] seq [9];
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    chk("reset_mask", 32'(load_mask), 32'h0);
    chk("reset_cnt", 32'(frame_count), 32'h0);
    chk("reset_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;

    // In-order fill with 11..77
    for (int i = 1; i <= 7; i++) drive(1'b1, 3'(i), 8'(i * 17), 1'b0);
    chk("inorder_fv", 32'(frame_valid), 32'h1);
    chk("inorder_A", 32'(out_A), 32'h11);
    chk("inorder_D", 32'(out_D), 32'h44);
    chk("inorder_G", 32'(out_G), 32'h77);
    chk("inorder_mask", 32'(load_mask), 32'h7F);
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    chk("hs_fv", 32'(frame_valid), 32'h0);
    chk("hs_mask", 32'(load_mask), 32'h0);
    chk("hs_cnt", 32'(frame_count), 32'h1);

    // Out-of-order fill with nulls
    seq = '{3'd7, 3'd0, 3'd1, 3'd0, 3'd4, 3'd2, 3'd6, 3'd3, 3'd5};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, seq[i], 8'hA0 + 8'(i), 1'b0);
      if (i == 3) chk("ooo_mask_partial", 32'(load_mask), 32'h41);
      if (i < 8) chk("ooo_fv_early", 32'(frame_valid), 32'h0);
    end
    chk("ooo_fv", 32'(frame_valid), 32'h1);
    chk("ooo_G", 32'(out_G), 32'hA0);
    chk("ooo_E", 32'(out_E), 32'hA8);
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    chk("ooo_cnt", 32'(frame_count), 32'h2);

    // Duplicate on lane A
    drive(1'b1, 3'd1, 8'hAA, 1'b0);
    chk("dup_first", 32'(dup_err), 32'h0);
    drive(1'b1, 3'd1, 8'h55, 1'b0);
    chk("dup_pulse", 32'(dup_err), 32'h1);
    chk("dup_mask", 32'(load_mask), 32'h01);
    for (int i = 2; i <= 7; i++) begin
      drive(1'b1, 3'(i), 8'h30 + 8'(i), 1'b0);
      if (i == 2) chk("dup_clear", 32'(dup_err), 32'h0);
    end
    chk("dup_fv", 32'(frame_valid), 32'h1);
    chk("dup_A", 32'(out_A), 32'h55);
    drive(1'b0, 3'd0, 8'h00, 1'b1);

    // Back-pressure
    fill(8'h60);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd1, 8'hEE, 1'b0);
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_A", 32'(out_A), 32'h61);
    end
    drive(1'b1, 3'd1, 8'hEE, 1'b1);
    chk("bp_hs_ready", 32'(in_ready), 32'h1);
    chk("bp_hs_mask", 32'(load_mask), 32'h0);
    chk("bp_hs_A", 32'(out_A), 32'h61);
    drive(1'b1, 3'd1, 8'hEE, 1'b0);
    chk("bp_next_A", 32'(out_A), 32'hEE);
    chk("bp_next_mask", 32'(load_mask), 32'h01);
    chk("bp_cnt", 32'(frame_count), 32'h4);

    // Reset with four lanes loaded
    for (int i = 2; i <= 4; i++) drive(1'b1, 3'(i), 8'h90, 1'b0);
    chk("mid_mask", 32'(load_mask), 32'h0F);
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("mid_rst_A", 32'(out_A), 32'h0);
    chk("mid_rst_D", 32'(out_D), 32'h0);
    chk("mid_rst_mask", 32'(load_mask), 32'h0);
    chk("mid_rst_cnt", 32'(frame_count), 32'h0);

    // Reset while holding a frame, with frame_ready high
    fill(8'h10);
    chk("hold_fv", 32'(frame_valid), 32'h1);
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b1);
    rst = 1'b0;
    chk("hold_rst_fv", 32'(frame_valid), 32'h0);
    chk("hold_rst_cnt", 32'(frame_count), 32'h0);

    // 256 frames wrap the counter back to zero
    for (int f = 0; f < 256; f++) begin
      fill(8'(f));
      drive(1'b0, 3'd0, 8'h00, 1'b1);
      if (f == 254) chk("wrap_255", 32'(frame_count), 32'hFF);
    end
    chk("wrap_0", 32'(frame_count), 32'h0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
